// File: rtl/ddr_ctrl_pkg.sv
// Shared types and constants for the DDR read/write scheduler.
package ddr_ctrl_pkg;

  localparam int unsigned ADDR_W   = 30;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned STREAK_W = 4;
  localparam int unsigned WDOG_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_WR_BUSY = 3'b010,
    ST_RD_BUSY = 3'b100
  } state_t;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_t;

  // Streak after a grant: saturating count of same-direction grants, 1 on a switch.
  function automatic logic [STREAK_W-1:0] streak_step(
    input logic [STREAK_W-1:0] cur,
    input logic                same_dir,
    input logic [STREAK_W-1:0] limit
  );
    if (!same_dir) return STREAK_W'(1);
    return (cur >= limit) ? limit : STREAK_W'(cur + 1'b1);
  endfunction

endpackage

// File: rtl/ddr_rw_scheduler.sv
// Arbitrates the single DDR AXI port between write and read paths, one burst at a time.
// Optional busy watchdog enabled by defining RW_TIMEOUT_EN.
module ddr_rw_scheduler
  import ddr_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STREAK     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              axi_wr_start,
  output logic [ADDR_W-1:0] axi_wr_addr,
  output logic [LEN_W-1:0]  axi_wr_len,
  output logic              axi_rd_start,
  output logic [ADDR_W-1:0] axi_rd_addr,
  output logic [LEN_W-1:0]  axi_rd_len,
  output logic              timeout_err
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  generate
    if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_streak
      $error("MAX_STREAK must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65536");
    end
  endgenerate

  state_t              state;
  logic                last_dir;
  logic [STREAK_W-1:0] streak;
  burst_t              wr_burst;
  burst_t              rd_burst;

  logic keep_dir;
  logic grant_wr;
  logic grant_rd;
  logic grant_dir;
  logic done_hit;
  logic expire;

  assign axi_wr_addr = wr_burst.addr;
  assign axi_wr_len  = wr_burst.len;
  assign axi_rd_addr = rd_burst.addr;
  assign axi_rd_len  = rd_burst.len;

  // Grant decision. streak==0 means no grant yet since reset, so a tie goes to write.
  always_comb begin
    keep_dir = (streak != '0) && (streak < STREAK_MAX);
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == ST_IDLE) begin
      if (wr_req && rd_req) begin
        grant_wr = keep_dir ? (last_dir == DIR_WR) : (last_dir == DIR_RD);
        grant_rd = !grant_wr;
      end else begin
        grant_wr = wr_req;
        grant_rd = rd_req;
      end
    end
    grant_dir = grant_rd ? DIR_RD : DIR_WR;
    done_hit  = ((state == ST_WR_BUSY) && wr_done) || ((state == ST_RD_BUSY) && rd_done);
  end

`ifdef RW_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_err;

  // A done on the expiry cycle takes priority over the timeout.
  assign expire = (state != ST_IDLE) && !done_hit &&
                  (wdog_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = wdog_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == ST_IDLE) wdog_cnt <= '0;
      else                  wdog_cnt <= wdog_cnt + 1'b1;
      if (expire) wdog_err <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Scheduler FSM with registered grant pulses and latched burst descriptors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      last_dir     <= DIR_RD;
      streak       <= '0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      axi_wr_start <= 1'b0;
      axi_rd_start <= 1'b0;
      wr_burst     <= '0;
      rd_burst     <= '0;
    end else begin
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      axi_wr_start <= 1'b0;
      axi_rd_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_wr || grant_rd) begin
            streak   <= streak_step(streak, grant_dir == last_dir, STREAK_MAX);
            last_dir <= grant_dir;
            if (grant_wr) begin
              wr_ack       <= 1'b1;
              axi_wr_start <= 1'b1;
              wr_burst     <= '{addr: wr_addr, len: wr_len};
              state        <= ST_WR_BUSY;
            end else begin
              rd_ack       <= 1'b1;
              axi_rd_start <= 1'b1;
              rd_burst     <= '{addr: rd_addr, len: rd_len};
              state        <= ST_RD_BUSY;
            end
          end
        end
        ST_WR_BUSY, ST_RD_BUSY: begin
          if (done_hit || expire) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Randomized scoreboard bench for ddr_rw_scheduler; timeout scenario runs when RW_TIMEOUT_EN is defined.
module tb_ddr_rw_scheduler;

  localparam int unsigned MAX_STREAK     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req;
  logic [29:0] wr_addr, rd_addr;
  logic [7:0]  wr_len, rd_len;
  logic        wr_done, rd_done;
  logic        wr_ack, rd_ack, axi_wr_start, axi_rd_start, timeout_err;
  logic [29:0] axi_wr_addr, axi_rd_addr;
  logic [7:0]  axi_wr_len, axi_rd_len;

  logic wr_done_r = 1'b0, rd_done_r = 1'b0;
  logic wr_done_s = 1'b0, rd_done_s = 1'b0;
  logic wr_done_d = 1'b0, rd_done_d = 1'b0;
  bit   stray_en  = 1'b0;
  bit   resp_en   = 1'b1;

  assign wr_done = wr_done_r | wr_done_s | wr_done_d;
  assign rd_done = rd_done_r | rd_done_s | rd_done_d;

  always #5 clk = ~clk;

  ddr_rw_scheduler #(.MAX_STREAK(MAX_STREAK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .wr_done(wr_done), .rd_done(rd_done),
    .wr_ack(wr_ack), .rd_ack(rd_ack),
    .axi_wr_start(axi_wr_start), .axi_wr_addr(axi_wr_addr), .axi_wr_len(axi_wr_len),
    .axi_rd_start(axi_rd_start), .axi_rd_addr(axi_rd_addr), .axi_rd_len(axi_rd_len),
    .timeout_err(timeout_err)
  );

  typedef struct {
    bit          dir;
    logic [29:0] addr;
    logic [7:0]  len;
  } exp_t;

  exp_t        exp_q[$];
  bit          hist[$];
  bit          m_busy, m_dir, m_err;
  int          m_cnt;
  logic [29:0] h_wa, h_ra;
  logic [7:0]  h_wl, h_rl;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arbitration: look at the history of grant directions.
  function automatic bit pick_dir(input bit w, input bit r);
    bit last;
    int run;
    if (w && !r) return 1'b0;
    if (r && !w) return 1'b1;
    if (hist.size() == 0) return 1'b0;
    last = hist[hist.size()-1];
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) run++;
    return (run < int'(MAX_STREAK)) ? last : !last;
  endfunction

  // Reference model: one outstanding burst, decisions only when idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_err = 1'b0; m_cnt = 0;
      hist.delete(); exp_q.delete();
      h_wa = '0; h_ra = '0; h_wl = '0; h_rl = '0;
    end else if (m_busy) begin
      if ((!m_dir && wr_done) || (m_dir && rd_done)) m_busy = 1'b0;
`ifdef RW_TIMEOUT_EN
      else if (m_cnt + 1 >= int'(TIMEOUT_CYCLES)) begin m_busy = 1'b0; m_err = 1'b1; end
      else m_cnt++;
`endif
    end else if (wr_req || rd_req) begin
      exp_t e;
      e.dir  = pick_dir(wr_req, rd_req);
      e.addr = e.dir ? rd_addr : wr_addr;
      e.len  = e.dir ? rd_len  : wr_len;
      exp_q.push_back(e);
      hist.push_back(e.dir);
      if (hist.size() > 32) void'(hist.pop_front());
      m_busy = 1'b1; m_dir = e.dir; m_cnt = 0;
    end
  end

  // Monitor: pops one expectation per grant the model issued, checks held outputs.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_ack || rd_ack || axi_wr_start || axi_rd_start) begin
        if (exp_q.size() == 0) begin
          chk("spurious_grant", {wr_ack, axi_wr_start, rd_ack, axi_rd_start}, 4'b0000);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_pulses", {wr_ack, axi_wr_start, rd_ack, axi_rd_start},
              mon_e.dir ? 4'b0011 : 4'b1100);
          if (mon_e.dir) begin h_ra = mon_e.addr; h_rl = mon_e.len; end
          else           begin h_wa = mon_e.addr; h_wl = mon_e.len; end
        end
      end else if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("missing_grant", {wr_ack, axi_wr_start, rd_ack, axi_rd_start},
            mon_e.dir ? 4'b0011 : 4'b1100);
      end
      chk("held_descriptors", {axi_wr_addr, axi_wr_len, axi_rd_addr, axi_rd_len},
          {h_wa, h_wl, h_ra, h_rl});
      chk("timeout_err", timeout_err, m_err);
    end
  end

  // AXI master stand-ins: complete each burst after a random delay.
  always begin
    @(negedge clk);
    if (axi_wr_start && resp_en) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      wr_done_r = 1'b1;
      @(negedge clk);
      wr_done_r = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (axi_rd_start && resp_en) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      rd_done_r = 1'b1;
      @(negedge clk);
      rd_done_r = 1'b0;
    end
  end

  always @(negedge clk) begin
    wr_done_s = stray_en && ($urandom_range(0, 31) == 0);
    rd_done_s = stray_en && ($urandom_range(0, 31) == 0);
  end

  task automatic wait_ack(input bit dir, input string name, output int t);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(dir ? rd_ack : wr_ack) && t < 300);
    chk(name, dir ? rd_ack : wr_ack, 1'b1);
  endtask

  task automatic requester(input bit dir, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (dir) begin rd_req = 1'b1; rd_addr = 30'($urandom); rd_len = 8'($urandom); end
      else     begin wr_req = 1'b1; wr_addr = 30'($urandom); wr_len = 8'($urandom); end
      wait_ack(dir, dir ? "rd_ack_wait" : "wr_ack_wait", t);
      if (dir) begin rd_req = 1'b0; rd_addr = 30'($urandom); end
      else     begin wr_req = 1'b0; wr_addr = 30'($urandom); end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs",
           {wr_ack, rd_ack, axi_wr_start, axi_rd_start, axi_wr_addr, axi_wr_len,
            axi_rd_addr, axi_rd_len, timeout_err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int    t;
    int    g;
    string seq;
    rst_n = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs_init",
           {wr_ack, rd_ack, axi_wr_start, axi_rd_start, axi_wr_addr, axi_wr_len,
            axi_rd_addr, axi_rd_len, timeout_err}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random contention with stray done pulses.
    stray_en = 1'b1;
    fork
      requester(1'b0, 50);
      requester(1'b1, 50);
    join
    stray_en = 1'b0;
    repeat (30) @(negedge clk);

    // Reset during a read burst, then a read is granted in one cycle.
    resp_en = 1'b0;
    rd_req = 1'b1; rd_addr = 30'h2abcdef; rd_len = 8'd7;
    wait_ack(1'b1, "rd_before_reset", t);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();
    resp_en = 1'b1;
    rd_req = 1'b1; rd_addr = 30'h0001234; rd_len = 8'd3;
    wait_ack(1'b1, "rd_after_reset", t);
    chk("rd_after_reset_latency", t, 1);
    rd_req = 1'b0;
    repeat (12) @(negedge clk);

    // Lone write with stray done pulses and a read request raised while busy.
    resp_en = 1'b0;
    wr_req = 1'b1; wr_addr = 30'h100; wr_len = 8'd15;
    wait_ack(1'b0, "lone_write", t);
    chk("lone_write_latency", t, 1);
    chk("lone_write_desc", {axi_wr_start, axi_wr_addr, axi_wr_len}, {1'b1, 30'h100, 8'd15});
    wr_req = 1'b0;
    rd_done_d = 1'b1; rd_req = 1'b1; rd_addr = 30'h55; rd_len = 8'd1;
    @(negedge clk);
    rd_done_d = 1'b0;
    repeat (18) @(negedge clk);
    chk("busy_holds_read", rd_ack, 1'b0);
    resp_en = 1'b1;
    wr_done_d = 1'b1;
    @(negedge clk);
    wr_done_d = 1'b0;
    wait_ack(1'b1, "read_after_write_done", t);
    chk("read_after_write_latency", t, 1);
    rd_req = 1'b0;
    repeat (12) @(negedge clk);
    wr_done_d = 1'b1;
    @(negedge clk);
    wr_done_d = 1'b0;
    repeat (3) @(negedge clk);

`ifdef RW_TIMEOUT_EN
    // Write with no done: watchdog frees the port, a pending read follows.
    resp_en = 1'b0;
    wr_req = 1'b1; wr_addr = 30'h3; wr_len = 8'd9;
    wait_ack(1'b0, "timeout_write", t);
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 30'h44; rd_len = 8'd2;
    resp_en = 1'b1;
    wait_ack(1'b1, "read_after_timeout", t);
    chk("timeout_latency", t, 9);
    rd_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("timeout_err_sticky", timeout_err, 1'b1);
`endif

    // Tie after reset goes to write, then the streak limit alternates in runs.
    do_reset();
    resp_en = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 30'($urandom); rd_addr = 30'($urandom);
    seq = "";
    g = 0;
    t = 0;
    while (g < 9 && t < 2000) begin
      @(negedge clk);
      t++;
      if (wr_ack) begin seq = {seq, "W"}; g++; wr_addr = 30'($urandom); wr_len = 8'($urandom); end
      if (rd_ack) begin seq = {seq, "R"}; g++; rd_addr = 30'($urandom); rd_len = 8'($urandom); end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    checks++;
    if (seq != "WWWWRRRRW") begin
      failures++;
      $display("FAIL streak_sequence actual=%s required=WWWWRRRRW", seq);
    end
    repeat (15) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
